// File: rtl/seq_alu_if.sv
// Issue/result handshake bundle between the register-read stage, seq_alu and write-back.
interface seq_alu_if #(
   parameter int WIDTH = 18
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags and an iterative shift-add multiplier.
// Define SEQ_ALU_FLAGS_EN to build the {N,Z,C,V} flag logic; otherwise flags reads 0.
module seq_alu #(
   parameter int WIDTH = 18,
   parameter int SHW   = 5
) (
   input  logic     clk,
   input  logic     reset,
   seq_alu_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             is_mul;
   logic             last_step;
   logic [WIDTH-1:0] alu_out;

   logic [WIDTH-1:0] result_p1;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mplier_step;

   function automatic logic [WIDTH-1:0] alu_res(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [SHW-1:0] s;
      s = y[SHW-1:0];
      case (f_op)
         OP_ADD:  return x + y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         OP_SUB:  return x + ~y + WIDTH'(1);
         OP_SHL:  return (32'(s) >= WIDTH) ? '0 : (x << s);
         OP_SHR:  return (32'(s) >= WIDTH) ? '0 : (x >> s);
         default: return '0;
      endcase
   endfunction

   assign is_mul    = (bus.op == OP_MUL);
   assign last_step = (count == CW'(1));
   assign alu_out   = alu_res(bus.op, bus.a, bus.b);

   // Right-shifting product: acc holds the high half, mplier drains into the low half.
   assign step_sum    = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : '0)};
   assign acc_step    = step_sum[WIDTH:1];
   assign mplier_step = {step_sum[0], mplier[WIDTH-1:1]};

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = is_mul ? BUSY : DONE;
         end
         BUSY: begin
            if (last_step) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
            if (bus.out_ready) state_nxt = bus.in_valid ? (is_mul ? BUSY : DONE) : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = bus.in_valid && bus.in_ready;

   // Stage p1: result register, written on a non-MUL accept or on the final multiply step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         result_p1 <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            if (is_mul) begin
               acc    <= '0;
               mcand  <= bus.a;
               mplier <= bus.b;
               count  <= CW'(WIDTH);
            end else begin
               result_p1 <= alu_out;
            end
         end else if (state == BUSY) begin
            acc    <= acc_step;
            mplier <= mplier_step;
            count  <= count - CW'(1);
            if (last_step) result_p1 <= mplier_step;
         end
      end
   end

   assign bus.result = result_p1;

`ifdef SEQ_ALU_FLAGS_EN
   logic [3:0] flags_p1;

   function automatic logic ovf(input logic signed [WIDTH-1:0] x,
                                input logic signed [WIDTH-1:0] y,
                                input logic signed [WIDTH-1:0] r);
      return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
   endfunction

   // Returns {C, V}; shifts report the last bit pushed out of the word.
   function automatic logic [1:0] alu_cv(input logic [2:0]       f_op,
                                         input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] yi;
      logic [SHW-1:0]   s;
      logic             c;
      logic             v;
      s   = y[SHW-1:0];
      yi  = (f_op == OP_SUB) ? ~y : y;
      sum = {1'b0, x} + {1'b0, yi} + {{WIDTH{1'b0}}, (f_op == OP_SUB)};
      c   = 1'b0;
      v   = 1'b0;
      case (f_op)
         OP_ADD, OP_SUB: begin
            c = sum[WIDTH];
            v = ovf(x, yi, sum[WIDTH-1:0]);
         end
         OP_SHL: if (32'(s) < WIDTH && s != '0)
            c = ((x >> (WIDTH - 32'(s))) & WIDTH'(1)) != '0;
         OP_SHR: if (32'(s) < WIDTH && s != '0)
            c = ((x >> (32'(s) - 32'd1)) & WIDTH'(1)) != '0;
         default: ;
      endcase
      return {c, v};
   endfunction

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic [1:0] cv);
      return {r[WIDTH-1], (r == '0), cv};
   endfunction

   // Stage p1: flags travel with result_p1.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_p1 <= '0;
      end else if (accept && !is_mul) begin
         flags_p1 <= mk_flags(alu_out, alu_cv(bus.op, bus.a, bus.b));
      end else if (state == BUSY && last_step) begin
         flags_p1 <= mk_flags(mplier_step, {(|acc_step), 1'b0});
      end
   end

   assign bus.flags = flags_p1;
`else
   assign bus.flags = 4'b0000;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed ops push expected results, a monitor pops on each handshake.
module tb_seq_alu;
   localparam int WIDTH = 18;
   localparam int SHW   = 5;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

`ifdef SEQ_ALU_FLAGS_EN
   localparam logic [3:0] FLAG_MASK = 4'hF;
`else
   localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

   typedef struct {
      logic [WIDTH-1:0] res;
      logic [3:0]       flg;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   seq_alu_if #(.WIDTH(WIDTH)) bus ();

   seq_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Call at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input bit expect_it, input logic [WIDTH-1:0] r, input logic [3:0] f,
                        input string name);
      exp_t e;
      bit   got;
      if (expect_it) begin
         e.res  = r;
         e.flg  = f & FLAG_MASK;
         e.name = name;
         sbq.push_back(e);
      end
      bus.op       = o;
      bus.a        = x;
      bus.b        = y;
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = bus.in_ready;
         @(posedge clk);
      end
      #1 bus.in_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_%s: in_ready never high, expected acceptance", name);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: result 0x%0h, expected no output", bus.result);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, "_result"}, 32'(bus.result), 32'(e.res));
            check({e.name, "_flags"}, 32'(bus.flags), 32'(e.flg));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy;
      int first_valid;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = OP_ADD;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      check("rst_result", 32'(bus.result), 0);
      check("rst_flags", 32'(bus.flags), 0);
      sync();
      reset = 1'b0;

      // Single-cycle ops, with a latency check on the first one.
      issue(OP_ADD, 18'h3FFFF, 18'h00001, 1, 18'h00000, 4'b0110, "add_wrap");
      @(negedge clk);
      check("add_latency_out_valid", 32'(bus.out_valid), 1);
      sync();
      issue(OP_SUB, 18'd5, 18'd7, 1, 18'h3FFFE, 4'b1000, "sub_borrow");
      issue(OP_ADD, 18'h1FFFF, 18'h00001, 1, 18'h20000, 4'b1001, "add_ovf");
      issue(OP_SUB, 18'd7, 18'd7, 1, 18'h00000, 4'b0110, "sub_equal");
      issue(OP_SUB, 18'h20000, 18'h00001, 1, 18'h1FFFF, 4'b0011, "sub_ovf");
      issue(OP_OR, 18'h000F0, 18'h00F00, 1, 18'h00FF0, 4'b0000, "or");

      // Multiply timing: 18 busy cycles, result visible in cycle 19.
      issue(OP_MUL, 18'd300, 18'd500, 1, 18'h249F0, 4'b1000, "mul_300x500");
      busy = 0;
      first_valid = 0;
      for (int k = 1; k <= 40 && first_valid == 0; k++) begin
         @(negedge clk);
         if (bus.out_valid) first_valid = k;
         else if (!bus.in_ready) busy++;
      end
      check("mul_busy_cycles", 32'(busy), 18);
      check("mul_valid_cycle", 32'(first_valid), 19);
      sync();
      issue(OP_MUL, 18'h20000, 18'd4, 1, 18'h00000, 4'b0110, "mul_hi");

      issue(OP_SHL, 18'h00003, 18'd17, 1, 18'h20000, 4'b1010, "shl17");
      issue(OP_SHR, 18'h3FFFF, 18'd18, 1, 18'h00000, 4'b0100, "shr18");
      issue(OP_SHR, 18'h00005, 18'd1, 1, 18'h00002, 4'b0010, "shr1");
      issue(OP_SHL, 18'h00025, 18'd0, 1, 18'h00025, 4'b0000, "shl0");
      repeat (3) sync();

      // Backpressure: hold the ADD result, then release it together with a new XOR.
      bus.out_ready = 1'b0;
      issue(OP_ADD, 18'h00010, 18'h00020, 1, 18'h00030, 4'b0000, "add_hold");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_result", 32'(bus.result), 32'h30);
         check("hold_out_valid", 32'(bus.out_valid), 1);
         check("hold_in_ready", 32'(bus.in_ready), 0);
      end
      sync();
      bus.out_ready = 1'b1;
      issue(OP_XOR, 18'h0F0F0, 18'h0FFFF, 1, 18'h00F0F, 4'b0000, "xor_b2b");
      @(negedge clk);
      check("xor_no_bubble", 32'(bus.out_valid), 1);
      sync();

      // Reset in the middle of a multiply aborts it.
      issue(OP_MUL, 18'd300, 18'd500, 0, '0, 4'b0000, "mul_abort");
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      sync();
      reset = 1'b0;
      @(negedge clk);
      check("abort_out_valid", 32'(bus.out_valid), 0);
      check("abort_in_ready", 32'(bus.in_ready), 1);
      check("abort_result", 32'(bus.result), 0);
      sync();
      issue(OP_AND, 18'h00003, 18'h00006, 1, 18'h00002, 4'b0000, "and_after_abort");

      for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
      end
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
